// File: rtl/fpaddsub_norm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fpaddsub_norm_pkg
// Purpose  : Shared definitions for the FP add/sub normalisation shifter:
//            default widths, stage-count helpers, the stage payload record
//            and the leading-zero-count function used by the optional
//            NORM_LZC_EN build.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fpaddsub_norm_pkg;

  localparam int MANT_W     = 26;
  localparam int SHIFT_W    = 5;
  localparam int TAG_DEF_W  = 8;
  // Widest mantissa the leading-zero counter handles.
  localparam int LZC_MAX_W  = 64;
  localparam int LZC_IDX_W  = 6;

  // Payload held in each pipeline stage, at the default widths.
  typedef struct packed {
    logic [MANT_W-1:0]    data;
    logic [SHIFT_W-1:0]   shift;
    logic [SHIFT_W-1:0]   shift_used;
    logic                 zero;
    logic [TAG_DEF_W-1:0] tag;
  } norm_payload_t;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int nstages(input int shw, input int lvl_per_stg);
    return (shw + lvl_per_stg - 1) / lvl_per_stg;
  endfunction

  // Leading zeros of the low w bits of value; returns w for an all-zero value.
  function automatic int lzc(input logic [LZC_MAX_W-1:0] value, input int w);
    int count;
    count = w;
    // Ascending scan so the highest set bit is the last one to update count.
    for (int i = 0; i < LZC_MAX_W; i++) begin
      if (i < w && value[LZC_IDX_W'(i)]) count = w - 1 - i;
    end
    return count;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fpaddsub_norm_shift_stage.sv
`default_nettype none
// ============================================================================
// Module   : fpaddsub_norm_shift_stage
// Purpose  : One pipeline stage of the normalisation shifter. Applies shift
//            levels FIRST_LVL .. FIRST_LVL+NUM_LVL-1 (level k shifts left by
//            2^k, zero fill) and registers the payload plus a valid bit.
// Ports    : clk, rst (async, active high); load = stage load enable from
//            the top-level handshake; in_* = incoming payload/valid;
//            out_* = registered payload/valid.
// Revision : 1.0 - initial release
// ============================================================================
module fpaddsub_norm_shift_stage
  import fpaddsub_norm_pkg::*;
#(
  parameter int WIDTH     = MANT_W,
  parameter int SHW       = SHIFT_W,
  parameter int TAG_W     = TAG_DEF_W,
  parameter int FIRST_LVL = 0,
  parameter int NUM_LVL   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SHW-1:0]   in_shift,
  input  logic [SHW-1:0]   in_shift_used,
  input  logic             in_zero,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [SHW-1:0]   out_shift,
  output logic [SHW-1:0]   out_shift_used,
  output logic             out_zero,
  output logic [TAG_W-1:0] out_tag
);

  // Shift bits consumed by this stage; cleared from the remaining shift.
  localparam logic [SHW-1:0] USED_MASK = SHW'(((1 << NUM_LVL) - 1) << FIRST_LVL);

  logic [WIDTH-1:0] shifted;

  for (genvar k = 0; k < NUM_LVL; k++) begin : g_lvl
    localparam int LVL = FIRST_LVL + k;
    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] d;
    if (k == 0) begin : g_first
      assign src = in_data;
    end else begin : g_next
      assign src = g_lvl[k-1].d;
    end
    // A shift distance >= WIDTH empties the vector, which is the intent.
    assign d = in_shift[LVL] ? (src << (2 ** LVL)) : src;
  end

  assign shifted = g_lvl[NUM_LVL-1].d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_shift      <= '0;
      out_shift_used <= '0;
      out_zero       <= 1'b0;
      out_tag        <= '0;
    end else if (load) begin
      out_valid <= in_valid;
      // A bubble only clears valid; payload is held so nothing toggles.
      if (in_valid) begin
        out_data       <= shifted;
        out_shift      <= in_shift & ~USED_MASK;
        out_shift_used <= in_shift_used;
        out_zero       <= in_zero;
        out_tag        <= in_tag;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fpaddsub_normalize_shift_pipe.sv
`default_nettype none
// ============================================================================
// Module   : fpaddsub_normalize_shift_pipe
// Purpose  : Pipelined zero-filling logarithmic left shifter that normalises
//            the post-add mantissa. LVL_PER_STG shift levels per registered
//            stage, valid/ready handshake with bubble collapsing, tag
//            passthrough.
// Ports    : CLK, RST (async, active high)
//            in_valid/in_ready, MminP, Shift, in_tag  - input beat
//            out_valid/out_ready, Mmin, shift_used, zero_flag, out_tag
//                                                      - output beat
// Options  : NORM_LZC_EN - when defined, stage 0 derives the shift from the
//            leading-zero count of MminP and the Shift port is ignored
//            (WIDTH must then be <= 64).
// Revision : 1.0 - initial release
// ============================================================================
module fpaddsub_normalize_shift_pipe
  import fpaddsub_norm_pkg::*;
#(
  parameter int WIDTH       = MANT_W,
  parameter int SHW         = SHIFT_W,
  parameter int LVL_PER_STG = 2,
  parameter int TAG_W       = TAG_DEF_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] MminP,
  input  logic [SHW-1:0]   Shift,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Mmin,
  output logic [SHW-1:0]   shift_used,
  output logic             zero_flag,
  output logic [TAG_W-1:0] out_tag
);

  localparam int NSTG = nstages(SHW, LVL_PER_STG);

  // Index 0 is the input side; index s+1 is the register of stage s.
  logic [NSTG:0]    stg_valid;
  logic [WIDTH-1:0] stg_data  [NSTG+1];
  logic [SHW-1:0]   stg_shift [NSTG+1];
  logic [SHW-1:0]   stg_used  [NSTG+1];
  logic [NSTG:0]    stg_zero;
  logic [TAG_W-1:0] stg_tag   [NSTG+1];
  logic [NSTG-1:0]  stg_load;
  logic [SHW-1:0]   first_shift;

`ifdef NORM_LZC_EN
  // Saturate at WIDTH, or at the largest encodable shift if that is smaller.
  localparam int LZC_SAT = (SHW >= clog2(WIDTH + 1)) ? WIDTH : (2 ** SHW) - 1;

  int   lz;
  logic unused_shift;
  assign unused_shift = ^Shift;

  always_comb begin
    lz = lzc(LZC_MAX_W'(MminP), WIDTH);
    if (lz > LZC_SAT) lz = LZC_SAT;
    first_shift = SHW'(lz);
  end
`else
  assign first_shift = Shift;
`endif

  assign stg_valid[0] = in_valid;
  assign stg_data[0]  = MminP;
  assign stg_shift[0] = first_shift;
  assign stg_used[0]  = first_shift;
  assign stg_zero[0]  = (MminP == '0);
  assign stg_tag[0]   = in_tag;

  // Stage s loads if any stage from s to the output is empty, or the
  // consumer takes the output beat. This flattens the ripple
  // "!valid[s] || load[s+1]" into a function of registered state only.
  for (genvar s = 0; s < NSTG; s++) begin : g_load
    assign stg_load[s] = out_ready | ~(&stg_valid[NSTG:s+1]);
  end

  for (genvar s = 0; s < NSTG; s++) begin : g_stage
    localparam int FIRST = s * LVL_PER_STG;
    localparam int CNT   = ((SHW - FIRST) < LVL_PER_STG) ? (SHW - FIRST) : LVL_PER_STG;

    fpaddsub_norm_shift_stage #(
      .WIDTH     (WIDTH),
      .SHW       (SHW),
      .TAG_W     (TAG_W),
      .FIRST_LVL (FIRST),
      .NUM_LVL   (CNT)
    ) u_stage (
      .clk            (CLK),
      .rst            (RST),
      .load           (stg_load[s]),
      .in_valid       (stg_valid[s]),
      .in_data        (stg_data[s]),
      .in_shift       (stg_shift[s]),
      .in_shift_used  (stg_used[s]),
      .in_zero        (stg_zero[s]),
      .in_tag         (stg_tag[s]),
      .out_valid      (stg_valid[s+1]),
      .out_data       (stg_data[s+1]),
      .out_shift      (stg_shift[s+1]),
      .out_shift_used (stg_used[s+1]),
      .out_zero       (stg_zero[s+1]),
      .out_tag        (stg_tag[s+1])
    );
  end

  assign in_ready   = stg_load[0];
  assign out_valid  = stg_valid[NSTG];
  assign Mmin       = stg_data[NSTG];
  assign shift_used = stg_used[NSTG];
  assign zero_flag  = stg_zero[NSTG];
  assign out_tag    = stg_tag[NSTG];

endmodule
`default_nettype wire
